// File: rtl/shiftreg_pkg.sv
// ============================================================================
// Module   : shiftreg_pkg
// Purpose  : Shared types and helpers for the 74HC595 chain driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shiftreg_pkg;

  localparam int BITS_PER_CHIP = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BIT_LO   = 3'd1,
    BIT_HI   = 3'd2,
    LATCH_LO = 3'd3,
    LATCH_HI = 3'd4
  } sr_state_t;

  function automatic int frame_width(input int n_chips);
    return n_chips * BITS_PER_CHIP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_tick_gen.sv
// ============================================================================
// Module   : sr_tick_gen
// Purpose  : Phase timer; pulses phase_done on the last cycle of each
//            CLK_DIV-cycle phase while run is high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic phase_done
);

  generate
    if (CLK_DIV == 1) begin : g_div1
      // Every cycle is a whole phase, so no counter is needed.
      assign phase_done = run & ~restart;
    end else begin : g_divn
      localparam int CNT_W = $clog2(CLK_DIV);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (restart || !run || (cnt == LAST)) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign phase_done = run && !restart && (cnt == LAST);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/shiftreg_chain.sv
// ============================================================================
// Module   : shiftreg_chain
// Purpose  : Serialises one frame per handshake into a daisy chain of
//            74HC595s (SRCLK / SER / RCLK / OE_n).
// Options  : SHIFTREG_READBACK_EN adds i_SER_IN / o_Rdback chain readback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shiftreg_chain
  import shiftreg_pkg::*;
#(
  parameter int  N_CHIPS   = 2,
  parameter int  CLK_DIV   = 2,
  parameter bit  MSB_FIRST = 1'b1,
  localparam int W         = frame_width(N_CHIPS)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_Data,
  input  logic         i_Enable,
  output logic         o_Ready,
  output logic         o_SRCLK,
  output logic         o_SER_OUT,
  output logic         o_RCLK,
`ifdef SHIFTREG_READBACK_EN
  input  logic         i_SER_IN,
  output logic [W-1:0] o_Rdback,
`endif
  output logic         o_OE_n
);

  localparam int BCW = $clog2(W + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

  sr_state_t      state;
  sr_state_t      state_nx;
  logic [W-1:0]   shreg;
  logic [W-1:0]   shreg_shift;
  logic [BCW-1:0] bit_cnt;
  logic           ser;
  logic           oe_n;
  logic           accept;
  logic           phase_done;
  logic           last_bit;
  logic           bit_end;
  logic           latch_end;

  function automatic logic head(input logic [W-1:0] v);
    return MSB_FIRST ? v[W-1] : v[0];
  endfunction

  assign accept      = (state == IDLE) && i_Enable;
  assign last_bit    = (bit_cnt == LAST_BIT);
  assign bit_end     = (state == BIT_HI) && phase_done;
  assign latch_end   = (state == LATCH_HI) && phase_done;
  assign shreg_shift = MSB_FIRST ? {shreg[W-2:0], 1'b0} : {1'b0, shreg[W-1:1]};

  sr_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .restart    (accept),
    .run        (state != IDLE),
    .phase_done (phase_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    o_Ready  = 1'b0;
    o_SRCLK  = 1'b0;
    o_RCLK   = 1'b0;
    unique case (state)
      IDLE: begin
        o_Ready = 1'b1;
        if (i_Enable) state_nx = BIT_LO;
      end
      BIT_LO: begin
        if (phase_done) state_nx = BIT_HI;
      end
      BIT_HI: begin
        o_SRCLK = 1'b1;
        if (phase_done) state_nx = last_bit ? LATCH_LO : BIT_LO;
      end
      LATCH_LO: begin
        if (phase_done) state_nx = LATCH_HI;
      end
      LATCH_HI: begin
        o_RCLK = 1'b1;
        if (phase_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // SER is registered separately so it keeps the last transmitted bit in IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      ser     <= 1'b0;
    end else if (accept) begin
      shreg   <= i_Data;
      bit_cnt <= '0;
      ser     <= head(i_Data);
    end else if (bit_end) begin
      shreg <= shreg_shift;
      if (!last_bit) begin
        bit_cnt <= bit_cnt + BCW'(1);
        ser     <= head(shreg_shift);
      end
    end
  end

  // Outputs stay disabled until the first complete frame has been latched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      oe_n <= 1'b1;
    end else if (latch_end) begin
      oe_n <= 1'b0;
    end
  end

  assign o_SER_OUT = ser;
  assign o_OE_n    = oe_n;

`ifdef SHIFTREG_READBACK_EN
  logic [W-1:0] cap;
  logic [W-1:0] rdback;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cap    <= '0;
      rdback <= '0;
    end else begin
      if (bit_end) begin
        cap <= MSB_FIRST ? {cap[W-2:0], i_SER_IN} : {i_SER_IN, cap[W-1:1]};
      end
      if (latch_end) begin
        rdback <= cap;
      end
    end
  end

  assign o_Rdback = rdback;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shiftreg_chain.sv
// ============================================================================
// Module   : tb_shiftreg_chain
// Purpose  : Self-checking bench; two chain drivers (MSB-first CLK_DIV=2 and
//            LSB-first CLK_DIV=1) against a behavioural 595 chain model.
//            Honours SHIFTREG_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shiftreg_chain;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  logic         en     [2];
  logic [W-1:0] data   [2];
  logic         ready  [2];
  logic         srclk  [2];
  logic         ser    [2];
  logic         rclk   [2];
  logic         oe_n   [2];
`ifdef SHIFTREG_READBACK_EN
  logic         ser_in [2];
  logic [W-1:0] rdback [2];
`endif

  logic [W-1:0] seen_a       [2];
  logic [W-1:0] view_a       [2];
  logic [W-1:0] stage_view_a [2];
  int           srclk_a      [2];
  int           rclk_a       [2];
  int           rclkhi_a     [2];
  int           busy_a       [2];

  int errors = 0;
  int checks = 0;

  function automatic logic [W-1:0] bitrev16(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 2; k++) begin : g_inst
      localparam bit MSB = (k == 0);
      localparam int DIV = (k == 0) ? 2 : 1;

      shiftreg_chain #(
        .N_CHIPS   (2),
        .CLK_DIV   (DIV),
        .MSB_FIRST (MSB)
      ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_Data    (data[k]),
        .i_Enable  (en[k]),
        .o_Ready   (ready[k]),
        .o_SRCLK   (srclk[k]),
        .o_SER_OUT (ser[k]),
        .o_RCLK    (rclk[k]),
`ifdef SHIFTREG_READBACK_EN
        .i_SER_IN  (ser_in[k]),
        .o_Rdback  (rdback[k]),
`endif
        .o_OE_n    (oe_n[k])
      );

      // 595 chain: stage[0] is the near chip's QA, stage[W-1] the far chip's QH.
      logic [W-1:0] stage   = '0;
      logic [W-1:0] latch_q = '0;
      logic [W-1:0] seen    = '0;
      logic         qh_ret  = 1'b0;
      int           n_src   = 0;
      int           n_rclk  = 0;
      int           n_rhi   = 0;
      int           n_busy  = 0;

      // QH' returns through a retiming flop clocked by SRCLK, so the bit
      // presented during a shift is the one that just left the chain.
      always @(posedge srclk[k]) begin
        qh_ret <= stage[W-1];
        stage  <= {stage[W-2:0], ser[k]};
        seen   <= {seen[W-2:0], ser[k]};
        n_src  <= n_src + 1;
      end

      always @(posedge rclk[k]) begin
        latch_q <= stage;
        n_rclk  <= n_rclk + 1;
      end

      always @(posedge clk) begin
        if (rclk[k] === 1'b1) n_rhi <= n_rhi + 1;
        if (ready[k] === 1'b0) n_busy <= n_busy + 1;
      end

`ifdef SHIFTREG_READBACK_EN
      assign ser_in[k] = qh_ret;
`endif
      // An LSB-first board wires its pins in the opposite order, so the
      // parallel frame view is bit-reversed for that instance.
      assign seen_a[k]       = seen;
      assign view_a[k]       = MSB ? latch_q : bitrev16(latch_q);
      assign stage_view_a[k] = MSB ? stage : bitrev16(stage);
      assign srclk_a[k]      = n_src;
      assign rclk_a[k]       = n_rclk;
      assign rclkhi_a[k]     = n_rhi;
      assign busy_a[k]       = n_busy;
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input int k, input int budget, output logic last_oe);
    int n;
    n = 0;
    last_oe = oe_n[k];
    while (ready[k] !== 1'b1 && n < budget) begin
      last_oe = oe_n[k];
      @(negedge clk);
      n++;
    end
    chk("ready_return", 32'(ready[k]), 32'd1);
  endtask

  task automatic send(input int k, input logic [W-1:0] d);
    int           s_src, s_rclk, s_hi, s_busy, div;
    logic         oe_before, last_oe;
    logic [W-1:0] exp_rb;
    div       = (k == 0) ? 2 : 1;
    s_src     = srclk_a[k];
    s_rclk    = rclk_a[k];
    s_hi      = rclkhi_a[k];
    s_busy    = busy_a[k];
    oe_before = oe_n[k];
    exp_rb    = stage_view_a[k];
    data[k]   = d;
    en[k]     = 1'b1;
    @(negedge clk);
    en[k]   = 1'b0;
    data[k] = W'($urandom);
    chk("accept_ready_low", 32'(ready[k]), 32'd0);
    wait_ready(k, 200, last_oe);
    chk("ser_sequence", 32'(seen_a[k]), 32'((k == 0) ? d : bitrev16(d)));
    chk("latched_frame", 32'(view_a[k]), 32'(d));
    chk("srclk_edges", 32'(srclk_a[k] - s_src), 32'd16);
    chk("rclk_pulses", 32'(rclk_a[k] - s_rclk), 32'd1);
    chk("rclk_width", 32'(rclkhi_a[k] - s_hi), 32'(div));
    chk("busy_cycles", 32'(busy_a[k] - s_busy), 32'(2 * div * (W + 1)));
    chk("oe_n_enabled", 32'(oe_n[k]), 32'd0);
    if (oe_before) chk("oe_n_before_latch_end", 32'(last_oe), 32'd1);
    chk("ser_idle_hold", 32'(ser[k]), 32'((k == 0) ? d[0] : d[W-1]));
`ifdef SHIFTREG_READBACK_EN
    chk("rdback", 32'(rdback[k]), 32'(exp_rb));
`endif
  endtask

  initial begin
    int           s_src, s_rclk, s_busy, n;
    logic         last_oe;

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      en[k]   = 1'b1;
      data[k] = W'($urandom);
    end

    // Reset with enable held high: nothing may start.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_outputs", 32'({ready[k], srclk[k], ser[k], rclk[k], oe_n[k]}), 32'b10001);
      chk("reset_no_srclk", 32'(srclk_a[k]), 32'd0);
`ifdef SHIFTREG_READBACK_EN
      chk("reset_rdback", 32'(rdback[k]), 32'd0);
`endif
      en[k] = 1'b0;
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("idle_outputs", 32'({ready[k], srclk[k], ser[k], rclk[k], oe_n[k]}), 32'b10001);
      chk("idle_no_srclk", 32'(srclk_a[k]), 32'd0);
    end

    // Directed frames, then the readback pair.
    send(0, 16'hA5C3);
    send(1, 16'hA5C3);
    send(1, 16'h1234);
    send(1, 16'h5678);
    send(0, 16'h1234);
    send(0, 16'h5678);

    // Back-to-back with enable held (CLK_DIV=1 instance).
    s_src  = srclk_a[1];
    s_busy = busy_a[1];
    data[1] = 16'hFFFF;
    en[1]   = 1'b1;
    @(negedge clk);
    chk("b2b_accept_ready_low", 32'(ready[1]), 32'd0);
    data[1] = 16'h0000;
    wait_ready(1, 100, last_oe);
    chk("b2b_first_seq", 32'(seen_a[1]), 32'hFFFF);
    chk("b2b_first_latch", 32'(view_a[1]), 32'hFFFF);
    @(negedge clk);
    chk("b2b_ready_one_cycle", 32'(ready[1]), 32'd0);
    en[1]   = 1'b0;
    data[1] = W'($urandom);
    wait_ready(1, 100, last_oe);
    chk("b2b_second_seq", 32'(seen_a[1]), 32'h0000);
    chk("b2b_second_latch", 32'(view_a[1]), 32'h0000);
    chk("b2b_srclk_edges", 32'(srclk_a[1] - s_src), 32'd32);
    chk("b2b_busy_cycles", 32'(busy_a[1] - s_busy), 32'(2 * 2 * (W + 1)));

    // Random frames on both instances.
    for (int i = 0; i < 3; i++) begin
      send(0, W'($urandom));
      send(1, W'($urandom));
    end

    // Abort after bit 5 of a frame.
    s_src  = srclk_a[0];
    s_rclk = rclk_a[0];
    data[0] = W'($urandom);
    en[0]   = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    n = 0;
    while ((srclk_a[0] - s_src) < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_bit5", 32'(srclk_a[0] - s_src), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({ready[0], srclk[0], ser[0], rclk[0], oe_n[0]}), 32'b10001);
    repeat (6) @(negedge clk);
    chk("abort_no_rclk", 32'(rclk_a[0] - s_rclk), 32'd0);
    chk("abort_no_more_srclk", 32'(srclk_a[0] - s_src), 32'd6);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, W'($urandom));
    send(1, W'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shiftreg_chain.md
Name: shiftreg_chain

Overview:
Parametrised driver for a daisy-chain of N_CHIPS 74HC595 shift registers. It serialises one 8*N_CHIPS-bit frame per handshake and generates SRCLK, SER and RCLK with a programmable bit rate. It adds chain-length generalisation, bit-order selection and output-enable sequencing. It sits between a frame producer (Control-style sequencer using an i_Enable/o_Ready handshake) and the chip pins.

Parameters:
N_CHIPS, 2, number of cascaded 595s; frame width W = 8*N_CHIPS; legal range >= 1.
CLK_DIV, 2, i_clk cycles per SRCLK half-period; legal range >= 1.
MSB_FIRST, 1, 1 = bit W-1 shifted first (lands in the far chip's QH); 0 = bit 0 first.

Ports:
i_clk  input  1  system clock, all logic on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_Data  input  W  frame to shift; sampled only at accept.
i_Enable  input  1  frame request.
o_Ready  output  1  idle and able to accept a frame.
o_SRCLK  output  1  595 shift clock.
o_SER_OUT  output  1  595 serial data.
o_RCLK  output  1  595 storage (latch) clock.
o_OE_n  output  1  595 output enable, active low.

Behaviour:
- Reset (async assert, sync release): o_Ready=1, o_SRCLK=0, o_SER_OUT=0, o_RCLK=0, o_OE_n=1. State=IDLE, counters=0, shift register=0. Assertion mid-frame aborts the frame immediately and drives these values; no partial latch is issued.
- Accept: rising edge where i_Enable=1 and o_Ready=1. i_Data is copied to the internal shift register and o_Ready goes 0 on the next cycle. i_Enable is ignored while o_Ready=0. Changes to i_Data after accept have no effect.
- FSM states: IDLE -> BIT_LO -> BIT_HI -> (BIT_LO for the next bit | LATCH_LO after the last bit) -> LATCH_HI -> IDLE.
- BIT_LO: CLK_DIV cycles. SRCLK=0. SER_OUT holds the current bit, valid from the first cycle of BIT_LO (setup = CLK_DIV cycles).
- BIT_HI: CLK_DIV cycles. SRCLK=1. SER_OUT is stable (hold = CLK_DIV cycles).
- Bit order: the shift register moves one position after each BIT_HI; direction is set by MSB_FIRST.
- Bit counter: counts 0..W-1, width $clog2(W+1). Frame ends after bit W-1.
- LATCH_LO: CLK_DIV cycles, SRCLK=0, RCLK=0.
- LATCH_HI: CLK_DIV cycles, RCLK=1.
- Exit to IDLE: RCLK returns to 0 and o_Ready returns to 1 on the same edge.
- Frame busy time: o_Ready is low for exactly 2*CLK_DIV*(W+1) cycles.
- SER_OUT in IDLE: holds its last value.
- o_OE_n goes 0 on the edge that ends the first LATCH_HI after reset and stays 0 until the next reset, so power-up garbage is never displayed.
- Back-to-back frames: if i_Enable is held high, a new frame is accepted in the single cycle o_Ready=1; o_Ready is high for exactly one cycle between frames.
- Divider: the counter width is $clog2(CLK_DIV). With CLK_DIV=1 each phase lasts one cycle, and the design must still work.

Optional Feature:
Macro SHIFTREG_READBACK_EN.
- Defined: extra ports i_SER_IN (1, from the last chip's QH') and o_Rdback (W). i_SER_IN is sampled on the last cycle of each BIT_HI and shifted into the capture register in the same order as transmission. o_Rdback updates when o_Ready rises and holds until the next frame completes. Reset value of o_Rdback = 0. The captured value is the chain's previous contents.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package shiftreg_pkg contains:
  - state enum: IDLE, BIT_LO, BIT_HI, LATCH_LO, LATCH_HI.
  - constant BITS_PER_CHIP=8.
  - helper function for frame width.
- Sub-module sr_tick_gen: CLK_DIV phase counter. Takes a restart input and emits a one-cycle phase_done pulse; it has the same async reset.

Test Plan:
- Reset then idle: with N_CHIPS=2, CLK_DIV=2, all outputs hold reset values. i_Enable pulsed during reset -> no SRCLK edges.
- Single frame, i_Data=16'hA5C3, MSB_FIRST=1: SER on the 16 SRCLK rising edges = 1010010111000011. Exactly one RCLK pulse of 2 cycles follows. o_Ready is low for 68 cycles. o_OE_n falls at the end of the latch.
- MSB_FIRST=0, same data: bit sequence is reversed (1100001110100101). A 2-chip 595 behavioural model latches 16'hA5C3.
- Held i_Enable, CLK_DIV=1, two frames 16'hFFFF then 16'h0000: o_Ready high for 1 cycle between them. Second frame starts correctly. i_Data change mid-frame is ignored.
- i_rst_n asserted after bit 5: outputs go to reset values in the same cycle, no RCLK pulse. The next frame after release completes normally.
- SHIFTREG_READBACK_EN with the model's QH' looped back: frame 16'h1234 then 16'h5678 -> o_Rdback = 0 after the first frame and 16'h1234 after the second.
